sfu_rownorm_stream: RTL and testbench

Parametrised, back-pressure-aware successor to the softmax SFU front end. It streams rows of signed fixed-point vectors and buffers each row while finding its global maximum. It then replays the row as `x - rowmax` with saturation, which is the max-subtraction stage of softmax. It sits between the streamer read port and the exp/sum datapath, and it also offers a bypass mode.

---
 rtl/sfu_rownorm_stream_if.sv | 11 +
 rtl/sfu_rownorm_stream.sv | 181 ++++++++++++++++++
 tb/tb_sfu_rownorm_stream.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfu_rownorm_stream_if.sv
// Valid/ready beat stream used for both the input and output ports of the row-normalize SFU.
interface sfu_rownorm_stream_if #(
  parameter int DataWidth = 256
) ();
  logic                 valid;
  logic                 ready;
  logic [DataWidth-1:0] bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/sfu_rownorm_stream.sv
// Softmax front end: buffers each row, finds its max, then replays x - rowmax with saturation.
// Bypass mode passes beats straight through for R*B handshakes.
module sfu_rownorm_stream #(
  parameter int LANES     = 16,
  parameter int ELEM_W    = 16,
  parameter int MAX_BEATS = 32,
  parameter int DataWidth = LANES * ELEM_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sfu_rownorm_stream_if.slave  ext_data_i,
  sfu_rownorm_stream_if.master ext_data_o,
  input  logic [31:0]          ext_csr_i_0,
  input  logic                 ext_start_i,
  output logic                 ext_busy_o,
  output logic                 ext_err_o,
  output logic [ELEM_W-1:0]    rowmax_o,
  output logic                 rowmax_vld_o
);

  localparam int IdxW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [ELEM_W-1:0] ElemMin = {1'b1, {(ELEM_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_BYPASS, ST_LOAD, ST_DRAIN} state_e;

  state_e                    state_q;
  logic [13:0]               rows_q, row_cnt_q;
  logic [15:0]               last_beat_q;
  logic [29:0]               total_q, byp_cnt_q;
  logic [IdxW-1:0]           wr_ptr_q, rd_ptr_q;
  logic signed [ELEM_W-1:0]  run_max_q, rowmax_q;
  logic                      rowmax_vld_q, err_q;
  logic [DataWidth-1:0]      row_buf_q [MAX_BEATS];

  logic [1:0]                csr_mode;
  logic [13:0]               csr_rows;
  logic [15:0]               csr_beats;
  logic                      start_ok;
  logic                      in_hs, out_hs;
  logic                      wr_last, rd_last, row_last, byp_last;
  logic signed [ELEM_W-1:0]  beat_max, lane_v, max_d;
  logic [DataWidth-1:0]      rd_word, drain_bits;
  logic signed [ELEM_W:0]    diff;

  assign csr_mode  = ext_csr_i_0[31:30];
  assign csr_rows  = ext_csr_i_0[29:16];
  assign csr_beats = ext_csr_i_0[15:0];
  assign start_ok  = !csr_mode[1] && (csr_rows != '0) && (csr_beats != '0)
                     && (csr_beats <= 16'(MAX_BEATS));

  assign in_hs    = ext_data_i.valid & ext_data_i.ready;
  assign out_hs   = ext_data_o.valid & ext_data_o.ready;
  assign wr_last  = (16'(wr_ptr_q) == last_beat_q);
  assign rd_last  = (16'(rd_ptr_q) == last_beat_q);
  assign row_last = (row_cnt_q == rows_q - 14'd1);
  assign byp_last = (byp_cnt_q == total_q - 30'd1);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    beat_max = ext_data_i.bits[ELEM_W-1:0];
    lane_v   = '0;
    for (int k = 1; k < LANES; k++) begin
      lane_v = ext_data_i.bits[k*ELEM_W +: ELEM_W];
      if (lane_v > beat_max) beat_max = lane_v;
    end
  end

  // The first beat of a row seeds the running max.
  assign max_d = ((wr_ptr_q == '0) || (beat_max > run_max_q)) ? beat_max : run_max_q;

  // Difference is never positive, so only the negative clamp is reachable.
  always_comb begin
    rd_word    = row_buf_q[rd_ptr_q];
    drain_bits = '0;
    diff       = '0;
    for (int k = 0; k < LANES; k++) begin
      diff = $signed({rd_word[k*ELEM_W+ELEM_W-1], rd_word[k*ELEM_W +: ELEM_W]})
           - $signed({rowmax_q[ELEM_W-1], rowmax_q});
      if (diff[ELEM_W] && !diff[ELEM_W-1]) drain_bits[k*ELEM_W +: ELEM_W] = ElemMin;
      else                                 drain_bits[k*ELEM_W +: ELEM_W] = diff[ELEM_W-1:0];
    end
  end

  always_comb begin
    ext_data_i.ready = 1'b0;
    ext_data_o.valid = 1'b0;
    ext_data_o.bits  = '0;
    unique case (state_q)
      ST_BYPASS: begin
        ext_data_o.valid = ext_data_i.valid;
        ext_data_i.ready = ext_data_o.ready;
        ext_data_o.bits  = ext_data_i.bits;
      end
      ST_LOAD:  ext_data_i.ready = 1'b1;
      ST_DRAIN: begin
        ext_data_o.valid = 1'b1;
        ext_data_o.bits  = drain_bits;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rows_q       <= '0;
      row_cnt_q    <= '0;
      last_beat_q  <= '0;
      total_q      <= '0;
      byp_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      run_max_q    <= '0;
      rowmax_q     <= '0;
      rowmax_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rowmax_vld_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (ext_start_i) begin
          if (start_ok) begin
            rows_q      <= csr_rows;
            last_beat_q <= csr_beats - 16'd1;
            total_q     <= 30'(csr_rows) * 30'(csr_beats);
            row_cnt_q   <= '0;
            byp_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= csr_mode[0] ? ST_LOAD : ST_BYPASS;
          end else begin
            err_q <= 1'b1;
          end
        end
        ST_BYPASS: if (out_hs) begin
          if (byp_last) state_q   <= ST_IDLE;
          else          byp_cnt_q <= byp_cnt_q + 30'd1;
        end
        ST_LOAD: if (in_hs) begin
          run_max_q <= max_d;
          if (wr_last) begin
            rowmax_q     <= max_d;
            rowmax_vld_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= ST_DRAIN;
          end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
        end
        ST_DRAIN: if (out_hs) begin
          if (rd_last) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            if (row_last) begin
              state_q <= ST_IDLE;
            end else begin
              row_cnt_q <= row_cnt_q + 14'd1;
              state_q   <= ST_LOAD;
            end
          end else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the row buffer has no reset; every entry is written in LOAD before DRAIN reads it.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_LOAD && in_hs) row_buf_q[wr_ptr_q] <= ext_data_i.bits;
  end

  assign ext_busy_o   = (state_q != ST_IDLE);
  assign ext_err_o    = err_q;
  assign rowmax_o     = rowmax_q;
  assign rowmax_vld_o = rowmax_vld_q;

endmodule

// File: tb/tb_sfu_rownorm_stream.sv
// Directed bench for sfu_rownorm_stream at LANES=4, ELEM_W=8: table-driven single rows plus
// multi-cycle sequences for backpressure, bypass, illegal starts and reset mid-run.
module tb_sfu_rownorm_stream;

  localparam int LANES = 4;
  localparam int ELEM_W = 8;
  localparam int MAX_BEATS = 32;
  localparam int DW = LANES * ELEM_W;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] csr;
  logic        start;
  logic        busy, err, rowmax_vld;
  logic [7:0]  rowmax;

  int n_checks = 0;
  int n_fail   = 0;

  sfu_rownorm_stream_if #(.DataWidth(DW)) in_if ();
  sfu_rownorm_stream_if #(.DataWidth(DW)) out_if ();

  sfu_rownorm_stream #(
    .LANES(LANES), .ELEM_W(ELEM_W), .MAX_BEATS(MAX_BEATS), .DataWidth(DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ext_data_i  (in_if),
    .ext_data_o  (out_if),
    .ext_csr_i_0 (csr),
    .ext_start_i (start),
    .ext_busy_o  (busy),
    .ext_err_o   (err),
    .rowmax_o    (rowmax),
    .rowmax_vld_o(rowmax_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] in0, in1, out0, out1;
    logic [7:0]  max;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [7:0] e8(input int x);
    logic [7:0] r;
    r = 8'(x);
    return r;
  endfunction

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {e8(d), e8(c), e8(b), e8(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One normalize row, R=1 B=2, output ready held high; optionally pokes start while busy.
  task automatic run_vec(input vec_t v, input bit poke);
    csr = {2'b01, 14'd1, 16'd2};
    start = 1'b1;
    out_if.ready = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s_busy_up", v.name), {31'b0, busy}, 32'd1);
    check($sformatf("%s_iready_up", v.name), {31'b0, in_if.ready}, 32'd1);
    in_if.valid = 1'b1;
    in_if.bits  = v.in0;
    if (poke) begin
      start = 1'b1;
      csr   = {2'b11, 14'd0, 16'd0};
    end
    tick();
    start = 1'b0;
    if (poke) begin
      check("busy_start_no_err", {31'b0, err}, 32'd0);
      check("busy_start_still_busy", {31'b0, busy}, 32'd1);
    end
    in_if.bits = v.in1;
    tick();
    in_if.valid = 1'b0;
    check($sformatf("%s_vld_pulse", v.name), {31'b0, rowmax_vld}, 32'd1);
    check($sformatf("%s_rowmax", v.name), {24'b0, rowmax}, {24'b0, v.max});
    check($sformatf("%s_out0", v.name), out_if.bits, v.out0);
    check($sformatf("%s_iready_drain", v.name), {31'b0, in_if.ready}, 32'd0);
    tick();
    check($sformatf("%s_vld_single", v.name), {31'b0, rowmax_vld}, 32'd0);
    check($sformatf("%s_out1", v.name), out_if.bits, v.out1);
    check($sformatf("%s_ovalid1", v.name), {31'b0, out_if.valid}, 32'd1);
    tick();
    check($sformatf("%s_busy_down", v.name), {31'b0, busy}, 32'd0);
    check($sformatf("%s_ovalid_down", v.name), {31'b0, out_if.valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_iready"}, {31'b0, in_if.ready}, 32'd0);
    check({tag, "_ovalid"}, {31'b0, out_if.valid}, 32'd0);
    check({tag, "_obits"}, out_if.bits, 32'd0);
    check({tag, "_rowmax"}, {24'b0, rowmax}, 32'd0);
    check({tag, "_rowmax_vld"}, {31'b0, rowmax_vld}, 32'd0);
  endtask

  int          t3_lane [12][4];
  logic [31:0] t3_word [12];
  logic [31:0] t3_exp  [12];
  int          t3_max  [3];
  logic [31:0] byp_word [5];
  logic [31:0] bad_csr [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int in_idx, out_idx, vlds, stall_err, drain_err, pass_err;
    bit stall, tog;
    logic [31:0] stall_bits;

    vecs[0] = '{"t1_basic", pack4(1, 5, -3, 2), pack4(7, 0, 7, -8),
                pack4(-6, -2, -10, -5), pack4(0, -7, 0, -15), e8(7)};
    vecs[1] = '{"t2_sat", pack4(127, -128, 0, 0), pack4(0, 0, 0, 0),
                pack4(0, -128, -127, -127), pack4(-127, -127, -127, -127), e8(127)};
    vecs[2] = '{"neg_row", pack4(-5, -9, -100, -128), pack4(-7, -6, -128, -50),
                pack4(0, -4, -95, -123), pack4(-2, -1, -123, -45), e8(-5)};
    bad_csr = '{{2'b01, 14'd1, 16'd0}, {2'b01, 14'd1, 16'(MAX_BEATS + 1)},
                {2'b01, 14'd0, 16'd2}, {2'b10, 14'd1, 16'd2}};

    rst_ni = 1'b0;
    csr = '0;
    start = 1'b0;
    in_if.valid = 1'b0;
    in_if.bits = '0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_vec(vecs[i], 1'b0);

    // Multi-row normalize: R=3, B=4, toggling output ready, random input valid.
    for (int r = 0; r < 3; r++) begin
      t3_max[r] = -1000;
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < 4; k++) begin
          t3_lane[r*4+b][k] = int'($urandom_range(0, 255)) - 128;
          if (t3_lane[r*4+b][k] > t3_max[r]) t3_max[r] = t3_lane[r*4+b][k];
        end
    end
    for (int j = 0; j < 12; j++) begin
      int e [4];
      for (int k = 0; k < 4; k++) begin
        e[k] = t3_lane[j][k] - t3_max[j/4];
        if (e[k] < -128) e[k] = -128;
      end
      t3_word[j] = pack4(t3_lane[j][0], t3_lane[j][1], t3_lane[j][2], t3_lane[j][3]);
      t3_exp[j]  = pack4(e[0], e[1], e[2], e[3]);
    end
    csr = {2'b01, 14'd3, 16'd4};
    start = 1'b1;
    tick();
    start = 1'b0;
    in_idx = 0; out_idx = 0; vlds = 0; stall_err = 0; drain_err = 0;
    stall = 1'b0; tog = 1'b0; stall_bits = '0;
    for (int cyc = 0; cyc < 400 && out_idx < 12; cyc++) begin
      in_if.valid  = (in_idx < 12) && ($urandom_range(0, 1) == 1);
      in_if.bits   = (in_idx < 12) ? t3_word[in_idx] : '0;
      out_if.ready = tog;
      tog = ~tog;
      @(negedge clk);
      if (stall && (!out_if.valid || out_if.bits !== stall_bits)) stall_err++;
      stall = out_if.valid && !out_if.ready;
      stall_bits = out_if.bits;
      if (out_if.valid && in_if.ready) drain_err++;
      if (rowmax_vld) begin
        if (vlds < 3) check($sformatf("t3_rowmax%0d", vlds), {24'b0, rowmax}, {24'b0, e8(t3_max[vlds])});
        vlds++;
      end
      if (in_if.valid && in_if.ready) in_idx++;
      if (out_if.valid && out_if.ready) begin
        check($sformatf("t3_out%0d", out_idx), out_if.bits, t3_exp[out_idx]);
        out_idx++;
      end
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    check("t3_out_count", out_idx, 32'd12);
    check("t3_stable_on_stall", stall_err, 32'd0);
    check("t3_iready_in_drain", drain_err, 32'd0);
    check("t3_vld_pulses", vlds, 32'd3);
    check("t3_busy_down", {31'b0, busy}, 32'd0);

    // Bypass: R=1, B=5, both sides throttled.
    for (int j = 0; j < 5; j++) byp_word[j] = $urandom;
    csr = {2'b00, 14'd1, 16'd5};
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy_up", {31'b0, busy}, 32'd1);
    in_idx = 0; vlds = 0; pass_err = 0;
    for (int cyc = 0; cyc < 400 && in_idx < 5; cyc++) begin
      in_if.valid  = ($urandom_range(0, 2) != 0);
      in_if.bits   = byp_word[in_idx];
      out_if.ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_if.valid !== in_if.valid || in_if.ready !== out_if.ready) pass_err++;
      if (rowmax_vld) vlds++;
      if (out_if.valid && out_if.ready) begin
        check($sformatf("t4_beat%0d", in_idx), out_if.bits, byp_word[in_idx]);
        in_idx++;
      end
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    check("t4_beat_count", in_idx, 32'd5);
    check("t4_zero_latency", pass_err, 32'd0);
    check("t4_no_rowmax_vld", vlds, 32'd0);
    check("t4_busy_down", {31'b0, busy}, 32'd0);

    // Illegal starts, then a start poked while busy.
    for (int i = 0; i < 4; i++) begin
      csr = bad_csr[i];
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("t5_err_pulse%0d", i), {31'b0, err}, 32'd1);
      check($sformatf("t5_busy_low%0d", i), {31'b0, busy}, 32'd0);
      tick();
      check($sformatf("t5_err_clear%0d", i), {31'b0, err}, 32'd0);
      check($sformatf("t5_busy_still_low%0d", i), {31'b0, busy}, 32'd0);
    end
    run_vec(vecs[0], 1'b1);

    // Reset during DRAIN of row 2 of 3.
    csr = {2'b01, 14'd3, 16'd2};
    start = 1'b1;
    out_if.ready = 1'b0;
    tick();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      in_if.valid = 1'b1;
      in_if.bits  = vecs[0].in0;
      tick();
      in_if.bits  = vecs[0].in1;
      tick();
      in_if.valid = 1'b0;
      if (r == 0) begin
        out_if.ready = 1'b1;
        tick();
        tick();
        out_if.ready = 1'b0;
      end
    end
    tick();
    check("t6_in_drain_busy", {31'b0, busy}, 32'd1);
    check("t6_in_drain_ovalid", {31'b0, out_if.valid}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_async");
    #2;
    rst_ni = 1'b1;
    tick();
    run_vec(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
